lsu_sub_word: RTL and testbench

- Load/store unit between the single-cycle CPU datapath and the 1024x32 word-addressed data memory.
- The data memory has a combinational read, a posedge word write, and no byte enables. This block turns byte/halfword/word loads and stores into whole-word memory accesses.
- Sub-word stores use a registered read-modify-write. Loads get sign or zero extension.
- The CPU stalls on req_ready.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_lane.sv | 39 +++
 rtl/lsu_sub_word.sv | 154 +++++++++++++++
 tb/tb_lsu_sub_word.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the sub-word load/store unit.
// Contents: access-size encodings, lane widths, FSM state type, small helpers.
// Configuration macro LSU_MISALIGN_TRAP_EN adds the ERR state.
package lsu_pkg;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;  // 2'b11 behaves as a word too

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LD   = 3'd1,
    ST_RMW  = 3'd2,
    ST_WR   = 3'd3
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    ST_ERR  = 3'd4
`endif
  } state_t;

  // Both 2'b10 and 2'b11 are whole-word accesses.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] low);
    return ((size == SZ_HALF) && low[0]) || (is_word(size) && (low != 2'b00));
  endfunction

  // Clears the low address bits that a half or word access cannot use.
  function automatic logic [1:0] align_low(input logic [1:0] size, input logic [1:0] low);
    if (is_word(size))       return 2'b00;
    else if (size == SZ_HALF) return {low[1], 1'b0};
    else                     return low;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational lane steering for sub-word accesses (little-endian).
// Ports: old_word/wdata/size/lane -> merged (store merge);
//        rd_word/size/lane/uns -> rdata (load extract with sign/zero extension).
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] old_word,
  input  logic [WORD_W-1:0] wdata,
  input  logic [WORD_W-1:0] rd_word,
  input  logic [1:0]        size,
  input  logic [1:0]        lane,
  input  logic              uns,
  output logic [WORD_W-1:0] merged,
  output logic [WORD_W-1:0] rdata
);

  logic [BYTE_W-1:0] ld_byte;
  logic [HALF_W-1:0] ld_half;

  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: merged[{lane, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
      SZ_HALF: merged[{lane[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
      default: merged = wdata;
    endcase
  end

  always_comb begin
    ld_byte = rd_word[{lane, 3'b000} +: BYTE_W];
    ld_half = rd_word[{lane[1], 4'b0000} +: HALF_W];
    case (size)
      SZ_BYTE: rdata = {{(WORD_W-BYTE_W){~uns & ld_byte[BYTE_W-1]}}, ld_byte};
      SZ_HALF: rdata = {{(WORD_W-HALF_W){~uns & ld_half[HALF_W-1]}}, ld_half};
      default: rdata = rd_word;
    endcase
  end

endmodule

// File: rtl/lsu_sub_word.sv
// lsu_sub_word: byte/half/word loads and stores onto a word-only memory
// (combinational read, posedge write, no byte enables); sub-word stores do RMW.
// Ports: req_* from CPU (stall on req_ready), rsp_* pulse back, dm_* to memory.
// Macro LSU_MISALIGN_TRAP_EN: misaligned requests trap via ERR/rsp_misalign
// instead of having their low address bits silently cleared.
module lsu_sub_word
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic              rsp_misalign,
`endif
  output logic [ADDR_W-3:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic              dm_we,
  input  logic [31:0]       dm_dout
);

  state_t state, next_state;

  logic              lat_we;
  logic [1:0]        lat_size;
  logic              lat_unsigned;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [31:0]       merge;
  logic [31:0]       rdata_hold;

  logic [ADDR_W-1:0] acc_addr;
  logic              accept;
  logic              req_mis;
  logic [31:0]       merged_word;
  logic [31:0]       ld_data;

  // Upper request address bits are outside the decoded memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_W];

  assign accept = req_valid && (state == ST_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_mis  = is_misaligned(req_size, req_addr[1:0]);
  assign acc_addr = req_addr[ADDR_W-1:0];
`else
  assign req_mis  = 1'b0;
  assign acc_addr = {req_addr[ADDR_W-1:2], align_low(req_size, req_addr[1:0])};
`endif

  lsu_lane u_lane (
    .old_word (dm_dout),
    .wdata    (lat_wdata),
    .rd_word  (dm_dout),
    .size     (lat_size),
    .lane     (lat_addr[1:0]),
    .uns      (lat_unsigned),
    .merged   (merged_word),
    .rdata    (ld_data)
  );

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    dm_we      = 1'b0;
    rsp_valid  = 1'b0;
    rsp_rdata  = rdata_hold;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_mis) begin
`ifdef LSU_MISALIGN_TRAP_EN
            next_state = ST_ERR;
`endif
          end else if (!req_we)           next_state = ST_LD;
          else if (is_word(req_size))     next_state = ST_WR;
          else                            next_state = ST_RMW;
        end
      end
      ST_LD: begin
        rsp_valid  = 1'b1;
        rsp_rdata  = ld_data;
        next_state = ST_IDLE;
      end
      ST_RMW: next_state = ST_WR;
      ST_WR: begin
        dm_we      = 1'b1;
        rsp_valid  = 1'b1;
        rsp_rdata  = 32'd0;
        next_state = ST_IDLE;
      end
`ifdef LSU_MISALIGN_TRAP_EN
      ST_ERR: begin
        rsp_valid  = 1'b1;
        rsp_rdata  = 32'd0;
        next_state = ST_IDLE;
      end
`endif
      default: next_state = ST_IDLE;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign rsp_misalign = (state == ST_ERR);
`endif

  // The index register doubles as the idle-time hold of dm_addr, and the
  // merge register (loaded with the full word for word stores) drives dm_din.
  assign dm_addr = lat_addr[ADDR_W-1:2];
  assign dm_din  = merge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      lat_we       <= 1'b0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= 32'd0;
      merge        <= 32'd0;
      rdata_hold   <= 32'd0;
    end else begin
      state <= next_state;
      if (accept) begin
        lat_we       <= req_we;
        lat_size     <= req_size;
        lat_unsigned <= req_unsigned;
        lat_addr     <= acc_addr;
        lat_wdata    <= req_wdata;
        if (next_state == ST_WR) merge <= req_wdata;
      end
      if (state == ST_RMW) merge <= merged_word;
      if (state == ST_LD)  rdata_hold <= ld_data;
      if (rsp_valid && (state != ST_LD)) rdata_hold <= 32'd0;
    end
  end

  // lat_we is kept for observability of the captured request; the state
  // already encodes direction, so it is not otherwise consumed.
  logic unused_lat_we;
  assign unused_lat_we = lat_we;

endmodule

// File: tb/tb_lsu_sub_word.sv
module tb_lsu_sub_word;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mis_sig;
  logic [9:0]  dm_addr;
  logic [31:0] dm_din;
  logic        dm_we;
  logic [31:0] dm_dout;

  always #5 clk = ~clk;

  lsu_sub_word #(.ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
`ifdef LSU_MISALIGN_TRAP_EN
    .rsp_misalign(mis_sig),
`endif
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout)
  );
`ifndef LSU_MISALIGN_TRAP_EN
  assign mis_sig = 1'b0;
`endif

  // Data memory environment with a backdoor preload port.
  logic [31:0] mem [1024];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_idx = '0;
  logic [31:0] pre_dat = '0;
  int          wr_count = 0;
  int          rsp_count = 0;
  assign dm_dout = mem[dm_addr];
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_dat;
    else if (dm_we) begin
      mem[dm_addr] <= dm_din;
      wr_count <= wr_count + 1;
    end
  end
  always @(posedge clk) if (rsp_valid) rsp_count <= rsp_count + 1;

  // Reference memory and behavioural model.
  logic [31:0] ref_mem [1024];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic ref_mis(input logic [1:0] sz, input logic [31:0] a);
    return (a % nbytes(sz)) != 0;
  endfunction

  // Byte offset within the word after clearing bits the size cannot use.
  function automatic int ref_off(input logic [1:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    return ((a % 4) / n) * n;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input int off, input logic uns);
    int n = nbytes(sz);
    logic [31:0] mask, v;
    if (n == 4) return w;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = (w >> (8 * off)) & mask;
    if (!uns && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] sz, input int off);
    int n = nbytes(sz);
    logic [31:0] mask;
    if (n == 4) return wd;
    mask = (32'd1 << (8 * n)) - 32'd1;
    return (old & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
  endfunction

  task automatic preload(input int idx, input logic [31:0] d);
    pre_idx = idx[9:0]; pre_dat = d; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
    ref_mem[idx] = d;
  endtask

  // Issue one request (called with clk low); returns at the negedge of the
  // response cycle.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic hold,
                        output logic [31:0] rd, output int lat, output logic mis,
                        output logic we_at_rsp, output int acc_wait);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    acc_wait = 0;
    rd = 32'd0; lat = 0; mis = 1'b0; we_at_rsp = 1'b0;
    while (req_ready !== 1'b1 && acc_wait < 20) begin
      @(negedge clk); acc_wait++;
    end
    if (req_ready !== 1'b1) begin
      check("accept_timeout", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    do begin
      @(negedge clk); lat++;
    end while (rsp_valid !== 1'b1 && lat < 10);
    if (rsp_valid !== 1'b1) begin
      check("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
      return;
    end
    rd = rsp_rdata; mis = mis_sig; we_at_rsp = dm_we;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_lat;
    logic        exp_mis;
    int          widx;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input string n, input logic we, input logic [1:0] sz,
                              input logic uns, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] erd, input int elat, input logic emis,
                              input int widx, input logic [31:0] ew);
    vec_t v;
    v.name = n; v.we = we; v.sz = sz; v.uns = uns; v.addr = a; v.wd = wd;
    v.exp_rd = erd; v.exp_lat = elat; v.exp_mis = emis; v.widx = widx; v.exp_word = ew;
    return v;
  endfunction

  initial begin
    logic [31:0] rd;
    int lat, aw, w0, r0;
    logic mis, wer;

    vecs[0]  = mk("lw_010",    0, 2'd2, 0, 32'h010, 0, 32'h11223344, 1, 0, -1, 0);
    vecs[1]  = mk("sb_012",    1, 2'd0, 0, 32'h012, 32'h000000AB, 0, 2, 0, 4, 32'h11AB3344);
    vecs[2]  = mk("lb_012",    0, 2'd0, 0, 32'h012, 0, 32'hFFFFFFAB, 1, 0, -1, 0);
    vecs[3]  = mk("lbu_012",   0, 2'd0, 1, 32'h012, 0, 32'h000000AB, 1, 0, -1, 0);
    vecs[4]  = mk("sh_012",    1, 2'd1, 0, 32'h012, 32'h0000BEEF, 0, 2, 0, 4, 32'hBEEF3344);
    vecs[5]  = mk("lh_012",    0, 2'd1, 0, 32'h012, 0, 32'hFFFFBEEF, 1, 0, -1, 0);
    vecs[6]  = mk("lhu_010",   0, 2'd1, 1, 32'h010, 0, 32'h00003344, 1, 0, -1, 0);
    vecs[7]  = mk("lb_013",    0, 2'd0, 0, 32'h013, 0, 32'hFFFFFFBE, 1, 0, -1, 0);
    vecs[8]  = mk("lhu_012",   0, 2'd1, 1, 32'h012, 0, 32'h0000BEEF, 1, 0, -1, 0);
    vecs[9]  = mk("lw_sz3",    0, 2'd3, 0, 32'h010, 0, 32'hBEEF3344, 1, 0, -1, 0);
    vecs[10] = mk("lw_hiaddr", 0, 2'd2, 1, 32'hABCD1010, 0, 32'hBEEF3344, 1, 0, -1, 0);
    vecs[11] = mk("sb_011_s",  0, 2'd0, 0, 32'h011, 0, 32'h00000033, 1, 0, -1, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[12] = mk("lw_011",    0, 2'd2, 0, 32'h011, 0, 32'h00000000, 1, 1, -1, 0);
`else
    vecs[12] = mk("lw_011",    0, 2'd2, 0, 32'h011, 0, 32'hBEEF3344, 1, 0, -1, 0);
`endif

    // Reset phase with preloads.
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    preload(4, 32'h11223344);
    preload(5, 32'h55667788);
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_dm_we",     {31'd0, dm_we}, 32'd0);
    check("rst_dm_addr",   {22'd0, dm_addr}, 32'd0);
    check("rst_dm_din",    dm_din, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("rst_misalign",  {31'd0, mis_sig}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      w0 = wr_count;
      do_req(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, 1'b0,
             rd, lat, mis, wer, aw);
      check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
      check({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
      check({vecs[i].name, "_we_at_rsp"}, {31'd0, wer}, {31'd0, vecs[i].we && !vecs[i].exp_mis});
`ifdef LSU_MISALIGN_TRAP_EN
      check({vecs[i].name, "_misalign"}, {31'd0, mis}, {31'd0, vecs[i].exp_mis});
`endif
      @(posedge clk); #1;
      check({vecs[i].name, "_writes"}, wr_count - w0, (vecs[i].we && !vecs[i].exp_mis) ? 1 : 0);
      check({vecs[i].name, "_rdata_held"}, rsp_rdata, vecs[i].exp_rd);
      if (vecs[i].widx >= 0) begin
        check({vecs[i].name, "_mem"}, mem[vecs[i].widx], vecs[i].exp_word);
        ref_mem[vecs[i].widx] = vecs[i].exp_word;
      end
      @(negedge clk);
    end

    // Back-to-back with req_valid held: sw then lw to the same word.
    do_req(1'b1, 2'd2, 1'b0, 32'h020, 32'hDEADBEEF, 1'b1, rd, lat, mis, wer, aw);
    check("b2b_sw_latency", lat, 1);
    check("b2b_sw_rdata", rd, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h020, 32'd0, 1'b0, rd, lat, mis, wer, aw);
    check("b2b_lw_accept_wait", aw, 1);
    check("b2b_lw_rdata", rd, 32'hDEADBEEF);
    ref_mem[8] = 32'hDEADBEEF;
    @(negedge clk);

    // Reset asserted during RMW of sb 0x014.
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h014;
    req_wdata = 32'h00000099; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    w0 = wr_count; r0 = rsp_count;
    check("rmw_busy", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1; #1;
    check("rmw_rst_dm_we", {31'd0, dm_we}, 32'd0);
    check("rmw_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("rmw_rst_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    check("rmw_rst_writes", wr_count - w0, 0);
    check("rmw_rst_rsps", rsp_count - r0, 0);
    check("rmw_rst_mem", mem[5], 32'h55667788);

    // Randomized traffic over word indices 0..7 against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic        we, uns, emis;
      logic [1:0]  sz;
      logic [31:0] a, wd, erd;
      int          idx, off;
      we = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 31));
      wd = $urandom;
      idx = int'(a[11:2]);
      off = ref_off(sz, a);
`ifdef LSU_MISALIGN_TRAP_EN
      emis = ref_mis(sz, a);
`else
      emis = 1'b0;
`endif
      erd = (emis || we) ? 32'd0 : ref_load(ref_mem[idx], sz, off, uns);
      w0 = wr_count;
      do_req(we, sz, uns, a, wd, 1'b0, rd, lat, mis, wer, aw);
      check("rnd_rdata", rd, erd);
      check("rnd_latency", lat, (we && !emis && nbytes(sz) != 4) ? 2 : 1);
`ifdef LSU_MISALIGN_TRAP_EN
      check("rnd_misalign", {31'd0, mis}, {31'd0, emis});
`endif
      @(posedge clk); #1;
      check("rnd_writes", wr_count - w0, (we && !emis) ? 1 : 0);
      if (we && !emis) begin
        ref_mem[idx] = ref_store(ref_mem[idx], wd, sz, off);
        check("rnd_mem", mem[idx], ref_mem[idx]);
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
